// File: rtl/bottle_line_ctrl.sv
// Bottling-station controller: conveyor, fill valve, cork sealer and cork
// magazine dispenser driven by one state machine, with station counters
// shown on a multiplexed 4-digit seven-segment display.
module bottle_line_ctrl #(
    parameter int CORK_CAP       = 9,
    parameter int REFILL_LOW     = 2,
    parameter int REFILL_BATCHES = 3,
    parameter int BATCH_SIZE     = 6,
    parameter int SCAN_DIV       = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       PG,
    input  logic       CH,
    input  logic       RELOAD,
    output logic       motor,
    output logic       valve,
    output logic       seal,
    output logic       dispense,
    output logic       alarm,
    output logic       low_corks,
    output logic [6:0] display,
    output logic [3:0] digitos
);

    localparam logic [3:0] CAP_C  = 4'(CORK_CAP);
    localparam logic [3:0] LOW_C  = 4'(REFILL_LOW);
    localparam logic [3:0] RB_C   = 4'(REFILL_BATCHES);
    localparam logic [3:0] BS_C   = 4'(BATCH_SIZE);
    localparam int         SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_FILL,
        S_SEAL,
        S_DISPENSE,
        S_EJECT,
        S_ALARM
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        corks_q, corks_d;
    logic [3:0]        refills_q, refills_d;
    logic [3:0]        bottles_q, bottles_d;
    logic [3:0]        boxes_q, boxes_d;
    logic [3:0]        corks_dec;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [3:0]        digit_q, digit_d;
    logic [3:0]        shown_code;

    // Seven-segment glyphs, bit 0 = segment a; non-decimal codes blank the digit
    function automatic logic [6:0] seg7(input logic [3:0] code);
        case (code)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign corks_dec = corks_q - 4'd1;

    // State register and station counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            corks_q   <= CAP_C;
            refills_q <= RB_C;
            bottles_q <= 4'd0;
            boxes_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            corks_q   <= corks_d;
            refills_q <= refills_d;
            bottles_q <= bottles_d;
            boxes_q   <= boxes_d;
        end
    end

    // Next-state logic; SEAL exit decisions use the post-decrement cork count
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (EN && corks_q != 4'd0) state_d = S_MOVE;
            end
            S_MOVE: begin
                if (!EN)     state_d = S_IDLE;
                else if (PG) state_d = S_FILL;
            end
            S_FILL: begin
                if (!EN)     state_d = S_IDLE;
                else if (CH) state_d = S_SEAL;
            end
            S_SEAL: begin
                if (corks_dec == 4'd0 && refills_q == 4'd0)
                    state_d = S_ALARM;
                else if (corks_dec <= LOW_C && refills_q != 4'd0)
                    state_d = S_DISPENSE;
                else
                    state_d = S_EJECT;
            end
            S_DISPENSE: state_d = S_EJECT;
            S_EJECT: begin
                if (!EN)      state_d = S_IDLE;
                else if (!PG) state_d = S_MOVE;
            end
            S_ALARM: begin
                if (RELOAD && RB_C != 4'd0) state_d = S_DISPENSE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter updates; a reload overrides the dispense decrement so that
    // ALARM -> DISPENSE ends with REFILL_BATCHES-1 refills left
    always_comb begin
        corks_d   = corks_q;
        refills_d = refills_q;
        bottles_d = bottles_q;
        boxes_d   = boxes_q;
        if (state_q == S_SEAL) begin
            corks_d = corks_dec;
            if (bottles_q + 4'd1 >= BS_C) begin
                bottles_d = 4'd0;
                boxes_d   = (boxes_q >= 4'd9) ? 4'd0 : boxes_q + 4'd1;
            end else begin
                bottles_d = bottles_q + 4'd1;
            end
        end
        if (state_q == S_DISPENSE) begin
            corks_d   = CAP_C;
            refills_d = refills_q - 4'd1;
        end
        if (RELOAD) refills_d = RB_C;
        if (RELOAD && state_q == S_DISPENSE) refills_d = RB_C - 4'd1;
    end

    // Moore output decode of the registered state
    always_comb begin
        motor     = (state_q == S_MOVE) || (state_q == S_EJECT);
        valve     = (state_q == S_FILL);
        seal      = (state_q == S_SEAL);
        dispense  = (state_q == S_DISPENSE);
        alarm     = (state_q == S_ALARM);
        low_corks = (corks_q <= LOW_C);
    end

    // Digit scan timer: rotate the one-hot enable every SCAN_DIV cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_q  <= '0;
            digit_q <= 4'b0001;
        end else begin
            scan_q  <= scan_d;
            digit_q <= digit_d;
        end
    end

    // Scan next-state
    always_comb begin
        scan_d  = scan_q + SCAN_W'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = {digit_q[2:0], digit_q[3]};
        end
    end

    // Display mux follows the enabled digit in the same cycle
    always_comb begin
        case (digit_q)
            4'b0001: shown_code = corks_q;
            4'b0010: shown_code = refills_q;
            4'b0100: shown_code = bottles_q;
            4'b1000: shown_code = boxes_q;
            default: shown_code = 4'hF;
        endcase
        display = seg7(shown_code);
        digitos = digit_q;
    end

endmodule

// File: tb/tb_bottle_line_ctrl.sv
// Directed bench for bottle_line_ctrl: two instances, one near defaults and
// one with a 3-cork magazine and no refill budget to reach the alarm.
module tb_bottle_line_ctrl;

    localparam logic [6:0] G0 = 7'h3F;
    localparam logic [6:0] G3 = 7'h4F;
    localparam logic [6:0] G9 = 7'h6F;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, EN, PG, CH, RELOAD;
    logic       motor_a, valve_a, seal_a, dispense_a, alarm_a, low_a;
    logic [6:0] display_a;
    logic [3:0] digitos_a;

    logic       ENb, PGb, CHb, RLb;
    logic       motor_b, valve_b, seal_b, dispense_b, alarm_b, low_b;
    logic [6:0] display_b;
    logic [3:0] digitos_b;

    int checks = 0;
    int errors = 0;
    int c_m, r_m, b_m, x_m;
    bit disp_m;

    bottle_line_ctrl #(
        .CORK_CAP(9), .REFILL_LOW(2), .REFILL_BATCHES(3),
        .BATCH_SIZE(6), .SCAN_DIV(4)
    ) dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .PG(PG), .CH(CH), .RELOAD(RELOAD),
        .motor(motor_a), .valve(valve_a), .seal(seal_a), .dispense(dispense_a),
        .alarm(alarm_a), .low_corks(low_a), .display(display_a), .digitos(digitos_a)
    );

    bottle_line_ctrl #(
        .CORK_CAP(3), .REFILL_LOW(2), .REFILL_BATCHES(0),
        .BATCH_SIZE(6), .SCAN_DIV(4)
    ) dut_b (
        .CLK(CLK), .RST(RST), .EN(ENb), .PG(PGb), .CH(CHb), .RELOAD(RLb),
        .motor(motor_b), .valve(valve_b), .seal(seal_b), .dispense(dispense_b),
        .alarm(alarm_b), .low_corks(low_b), .display(display_b), .digitos(digitos_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Leaves SEAL, checks counters against the bench model, returns to MOVE
    task automatic seal_exit_a;
        c_m--;
        b_m++;
        if (b_m == 6) begin
            b_m = 0;
            x_m = (x_m + 1) % 10;
        end
        disp_m = (c_m <= 2) && (r_m > 0);
        tick;
        check("seal_single", seal_a, 0);
        check("dispense_pulse", dispense_a, disp_m);
        check("corks_after_seal", dut_a.corks_q, c_m);
        check("bottles", dut_a.bottles_q, b_m);
        check("boxes", dut_a.boxes_q, x_m);
        if (disp_m) begin
            c_m = 9;
            r_m--;
            tick;
            check("dispense_single", dispense_a, 0);
            check("corks_refilled", dut_a.corks_q, c_m);
            check("refills_dec", dut_a.refills_q, r_m);
        end
        PG = 1'b0;
        tick;
        check("motor_resume", motor_a, 1);
    endtask

    // One bottle starting from MOVE with PG=0
    task automatic feed_a(input bit rl);
        PG = 1'b1;
        RELOAD = rl;
        tick;
        RELOAD = 1'b0;
        if (rl) r_m = 3;
        check("valve_fill", valve_a, 1);
        CH = 1'b1;
        tick;
        CH = 1'b0;
        check("seal_pulse", seal_a, 1);
        seal_exit_a();
    endtask

    initial begin
        RST = 1'b1; EN = 0; PG = 0; CH = 0; RELOAD = 0;
        ENb = 0; PGb = 0; CHb = 0; RLb = 0;
        tick;
        tick;
        check("rst_motor", motor_a, 0);
        check("rst_valve", valve_a, 0);
        check("rst_seal", seal_a, 0);
        check("rst_dispense", dispense_a, 0);
        check("rst_alarm", alarm_a, 0);
        check("rst_low", low_a, 0);
        check("rst_digitos", digitos_a, 4'b0001);
        check("rst_display", display_a, G9);
        check("rst_b_display", display_b, G3);
        check("rst_b_low", low_b, 0);
        RST = 1'b0;

        // Display scan: 9, 3, 0, 0 with a rotation every 4 cycles
        check("scan_d0", display_a, G9);
        repeat (4) tick;
        check("scan_en1", digitos_a, 4'b0010);
        check("scan_d1", display_a, G3);
        repeat (4) tick;
        check("scan_en2", digitos_a, 4'b0100);
        check("scan_d2", display_a, G0);
        repeat (4) tick;
        check("scan_en3", digitos_a, 4'b1000);
        check("scan_d3", display_a, G0);
        repeat (4) tick;
        check("scan_wrap", digitos_a, 4'b0001);
        repeat (5) tick;
        check("scan_mid", digitos_a, 4'b0010);
        #2 RST = 1'b1;
        #1;
        check("async_rst_digitos", digitos_a, 4'b0001);
        check("async_rst_display", display_a, G9);
        tick;
        RST = 1'b0;

        // Nominal cycle
        EN = 1'b1; PG = 1'b1;
        tick;
        check("nom_move_motor", motor_a, 1);
        check("nom_move_valve", valve_a, 0);
        tick;
        check("nom_fill_motor", motor_a, 0);
        check("nom_fill_valve", valve_a, 1);
        CH = 1'b1;
        tick;
        CH = 1'b0;
        check("nom_seal", seal_a, 1);
        check("nom_seal_valve", valve_a, 0);
        check("nom_corks_hold", dut_a.corks_q, 9);
        tick;
        check("nom_seal_end", seal_a, 0);
        check("nom_corks", dut_a.corks_q, 8);
        check("nom_eject_motor", motor_a, 1);
        PG = 1'b0;
        tick;
        check("nom_move_again", motor_a, 1);
        c_m = 8; r_m = 3; b_m = 1; x_m = 0;

        // Bottles 2..7: box completes at 6, dispense after 7
        repeat (5) feed_a(1'b0);
        check("box_bottles", dut_a.bottles_q, 0);
        check("box_count", dut_a.boxes_q, 1);
        feed_a(1'b0);
        check("after7_corks", dut_a.corks_q, 9);
        check("after7_refills", dut_a.refills_q, 2);

        // Reload outside ALARM only refreshes the refill budget
        RELOAD = 1'b1;
        tick;
        RELOAD = 1'b0;
        r_m = 3;
        check("reload_refills", dut_a.refills_q, 3);
        check("reload_motor", motor_a, 1);

        // 60 bottles: boxes wraps 9 -> 0 and lands back on 1
        for (int i = 0; i < 60; i++) feed_a(1'b1);
        check("wrap_boxes", dut_a.boxes_q, 1);
        check("wrap_bottles", dut_a.bottles_q, 1);

        // EN dropped mid-FILL, then resumed with the bottle still present
        PG = 1'b1;
        tick;
        check("en_fill", valve_a, 1);
        EN = 1'b0;
        tick;
        check("en_stop_valve", valve_a, 0);
        check("en_stop_motor", motor_a, 0);
        check("en_stop_corks", dut_a.corks_q, c_m);
        EN = 1'b1;
        tick;
        check("en_resume_move", motor_a, 1);
        tick;
        check("en_resume_fill", valve_a, 1);
        check("en_no_seal", seal_a, 0);
        tick;
        check("en_still_fill", valve_a, 1);
        check("en_still_no_seal", seal_a, 0);
        CH = 1'b1;
        tick;
        CH = 1'b0;
        check("en_seal", seal_a, 1);
        seal_exit_a();

        // Asynchronous reset mid-fill
        PG = 1'b1;
        tick;
        check("mf_valve", valve_a, 1);
        #2 RST = 1'b1;
        #1;
        check("mf_rst_valve", valve_a, 0);
        check("mf_rst_corks", dut_a.corks_q, 9);
        check("mf_rst_boxes", dut_a.boxes_q, 0);
        tick;
        RST = 1'b0; EN = 1'b0; PG = 1'b0;

        // Alarm: 3-cork magazine, no refill budget
        ENb = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            PGb = 1'b1;
            tick;
            CHb = 1'b1;
            tick;
            CHb = 1'b0;
            tick;
            if (i < 2) begin
                check("b_no_alarm", alarm_b, 0);
                PGb = 1'b0;
                tick;
            end
        end
        check("b_alarm", alarm_b, 1);
        check("b_alarm_motor", motor_b, 0);
        check("b_alarm_dispense", dispense_b, 0);
        check("b_low", low_b, 1);
        RLb = 1'b1;
        tick;
        RLb = 1'b0;
        check("b_reload_alarm", alarm_b, 1);
        check("b_reload_dispense", dispense_b, 0);
        tick;
        check("b_alarm_held", alarm_b, 1);
        check("b_alarm_motor_held", motor_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
